// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum support is enabled with IMEM_LOADER_CKSUM_EN.
package imem_loader_pkg;
  localparam int         IMEM_AW           = 8;
  localparam int         IMEM_DW           = 32;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_CKSUM, ST_DONE, ST_ERR
  } ld_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_ERR
  } ld_state_e;
`endif
endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler; pulses word_rdy the cycle after
// the 4th byte of a word is accepted.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr,
  input  logic               byte_vld,
  input  logic [7:0]         byte_data,
  output logic               last_byte,
  output logic               word_rdy,
  output logic [IMEM_DW-1:0] word
);
  logic [1:0]  cnt_q;
  logic [23:0] lo_q;

  assign last_byte = byte_vld && (cnt_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q    <= '0;
      lo_q     <= '0;
      word     <= '0;
      word_rdy <= 1'b0;
    end else begin
      word_rdy <= last_byte;
      if (clr) begin
        cnt_q <= '0;
      end else if (byte_vld) begin
        cnt_q <= cnt_q + 2'd1;
        case (cnt_q)
          2'd0:    lo_q[7:0]   <= byte_data;
          2'd1:    lo_q[15:8]  <= byte_data;
          2'd2:    lo_q[23:16] <= byte_data;
          default: word        <= {byte_data, lo_q};
        endcase
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Host byte-stream loader: SYNC, N, N little-endian words, optional XOR
// checksum (IMEM_LOADER_CKSUM_EN). Holds the core in reset until DONE.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0]         SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter logic [IMEM_AW-1:0] BASE_ADDR = 8'd0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         host_data_i,
  input  logic               host_valid_i,
  output logic               host_ready_o,
  input  logic               clear_i,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [IMEM_DW-1:0] imem_wdata_o,
  output logic               core_rst_o,
  output logic               done_o,
  output logic               err_o
);
  ld_state_e          state_q, state_d;
  logic [7:0]         n_q, widx_q;
  logic [IMEM_AW-1:0] addr_q;
  logic               acc, in_data, last_byte, word_rdy, last_word;
  logic [IMEM_DW-1:0] word;

  assign host_ready_o = (state_q != ST_ERR);
  assign acc          = host_valid_i && host_ready_o;
  assign in_data      = acc && (state_q == ST_DATA);
  // N=0 wraps to 255 here, giving the 256-word load.
  assign last_word    = last_byte && (widx_q == n_q - 8'd1);

  imem_word_packer u_pack (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr       (state_q == ST_LEN),
    .byte_vld  (in_data),
    .byte_data (host_data_i),
    .last_byte (last_byte),
    .word_rdy  (word_rdy),
    .word      (word)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc && state_q == ST_LEN) begin
        n_q    <= host_data_i;
        widx_q <= '0;
      end else if (last_byte) begin
        addr_q <= BASE_ADDR + widx_q;
        widx_q <= widx_q + 8'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] cks_q;
  always_ff @(posedge clk_i) begin
    if (!rst_i)                        cks_q <= '0;
    else if (acc && state_q == ST_LEN) cks_q <= '0;
    else if (in_data)                  cks_q <= cks_q ^ host_data_i;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (acc && host_data_i == SYNC_BYTE) state_d = ST_LEN;
      ST_LEN:   if (acc) state_d = ST_DATA;
`ifdef IMEM_LOADER_CKSUM_EN
      ST_DATA:  if (last_word) state_d = ST_CKSUM;
      ST_CKSUM: if (acc) state_d = (host_data_i == cks_q) ? ST_DONE : ST_ERR;
`else
      ST_DATA:  if (last_word) state_d = ST_DONE;
`endif
      ST_DONE:  if (acc && host_data_i == SYNC_BYTE) state_d = ST_LEN;
      ST_ERR:   if (clear_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Gating with rst_i kills a strobe already registered when reset arrives.
  assign imem_we_o    = word_rdy && rst_i;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = word;
  assign core_rst_o   = (state_q != ST_DONE);
  assign done_o       = (state_q == ST_DONE);
`ifdef IMEM_LOADER_CKSUM_EN
  assign err_o        = (state_q == ST_ERR);
`else
  assign err_o        = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, corner sequences and
// randomized loads against a stream-parsing reference model.
module tb_imem_loader;
  logic       clk = 1'b0, rst = 1'b0, vld = 1'b0, clr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rdy0, we0, crst0, done0, err0, rdy1, we1, crst1, done1, err1;
  logic [7:0] a0, a1;
  logic [31:0] d0, d1;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(8'h00)) u0 (
    .clk_i(clk), .rst_i(rst), .host_data_i(din), .host_valid_i(vld),
    .host_ready_o(rdy0), .clear_i(clr), .imem_we_o(we0), .imem_addr_o(a0),
    .imem_wdata_o(d0), .core_rst_o(crst0), .done_o(done0), .err_o(err0));

  imem_loader #(.BASE_ADDR(8'hFE)) u1 (
    .clk_i(clk), .rst_i(rst), .host_data_i(din), .host_valid_i(vld),
    .host_ready_o(rdy1), .clear_i(clr), .imem_we_o(we1), .imem_addr_o(a1),
    .imem_wdata_o(d1), .core_rst_o(crst1), .done_o(done1), .err_o(err1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0] wq0[$], wq1[$];
  int          wc0[$];
  always @(negedge clk) begin
    if (we0) begin wq0.push_back({a0, d0}); wc0.push_back(cyc); end
    if (we1) wq1.push_back({a1, d1});
  end

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; vld = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wq0.delete(); wq1.delete(); wc0.delete();
  endtask

  task automatic send(input logic [7:0] s[$], input bit gaps);
    foreach (s[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        vld = 1'b0; din = 8'($urandom); @(posedge clk); #1;
      end
      vld = 1'b1; din = s[i]; @(posedge clk); #1;
    end
    vld = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] s[$], input int from);
    logic [7:0] x = 8'h00;
    for (int k = from; k < s.size(); k++) x ^= s[k];
    return x;
  endfunction

  // Reference: find the first SYNC, read N, slice out whole words.
  logic [39:0] ew0[$], ew1[$];
  bit          e_done, e_err;
  task automatic model(input logic [7:0] s[$]);
    int i, n, avail, full;
    logic [31:0] w;
    ew0.delete(); ew1.delete(); e_done = 0; e_err = 0;
    i = -1;
    foreach (s[k]) if (i < 0 && s[k] == 8'hA5) i = k;
    if (i < 0 || i + 1 >= s.size()) return;
    n     = (s[i+1] == 8'h00) ? 256 : int'(s[i+1]);
    avail = s.size() - i - 2;
    full  = (avail / 4 > n) ? n : avail / 4;
    for (int k = 0; k < full; k++) begin
      w = {s[i+2+4*k+3], s[i+2+4*k+2], s[i+2+4*k+1], s[i+2+4*k]};
      ew0.push_back({8'(k), w});
      ew1.push_back({8'(254 + k), w});
    end
    if (full == n) begin
`ifdef IMEM_LOADER_CKSUM_EN
      if (avail > 4 * n) begin
        logic [7:0] x = 8'h00;
        for (int k = 0; k < 4 * n; k++) x ^= s[i+2+k];
        e_done = (s[i+2+4*n] == x);
        e_err  = !e_done;
      end
`else
      e_done = 1;
`endif
    end
  endtask

  task automatic compare(input string nm);
    chk({nm, " nwr0"}, 64'(wq0.size()), 64'(ew0.size()));
    chk({nm, " nwr1"}, 64'(wq1.size()), 64'(ew1.size()));
    for (int k = 0; k < wq0.size() && k < ew0.size(); k++) chk({nm, " wr0"}, 64'(wq0[k]), 64'(ew0[k]));
    for (int k = 0; k < wq1.size() && k < ew1.size(); k++) chk({nm, " wr1"}, 64'(wq1[k]), 64'(ew1[k]));
    chk({nm, " done"}, 64'(done0), 64'(e_done));
    chk({nm, " err"}, 64'(err0), 64'(e_err));
    chk({nm, " core_rst"}, 64'(crst0), 64'(!e_done));
    chk({nm, " ready"}, 64'(rdy0), 64'(!e_err));
    chk({nm, " done1"}, 64'(done1), 64'(e_done));
  endtask

  typedef struct {
    string      name;
    int         len;
    logic [7:0] b[16];
    int         nwr;
    logic [31:0] w0, w1;
    bit         done, err;
  } vec_t;
  vec_t tbl[3];

  initial begin
    logic [7:0] s[$];
    int bad, n;
    logic [7:0] b;

    tbl[0] = '{"basic", 12, '{8'h00, 8'h7F, 8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00, 8'h90, 8'h00, 8'h00, 8'h00},
               2, 32'h00000013, 32'h00100093, 1'b1, 1'b0};
    tbl[1] = '{"junk", 3, '{8'h00, 8'h7F, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               0, 32'h0, 32'h0, 1'b0, 1'b0};
`ifdef IMEM_LOADER_CKSUM_EN
    tbl[0].len = 13;
    tbl[2] = '{"badcks", 11, '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                               8'h10, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               2, 32'h00000013, 32'h00100093, 1'b0, 1'b1};
`else
    tbl[2] = '{"partial", 8, '{8'hA5, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1, 32'h00000013, 32'h0, 1'b0, 1'b0};
`endif

    do_reset();
    chk("rst we", 64'(we0), 64'(0));
    chk("rst addr", 64'(a0), 64'(0));
    chk("rst wdata", 64'(d0), 64'(0));
    chk("rst core_rst", 64'(crst0), 64'(1));
    chk("rst done", 64'(done0), 64'(0));
    chk("rst err", 64'(err0), 64'(0));
    chk("rst ready", 64'(rdy0), 64'(1));

    for (int t = 0; t < 3; t++) begin
      do_reset();
      s.delete();
      for (int k = 0; k < tbl[t].len; k++) s.push_back(tbl[t].b[k]);
      send(s, 1'b0);
      chk({tbl[t].name, " nwr"}, 64'(wq0.size()), 64'(tbl[t].nwr));
      if (wq0.size() > 0) begin
        chk({tbl[t].name, " a0"}, 64'(wq0[0][39:32]), 64'(8'h00));
        chk({tbl[t].name, " w0"}, 64'(wq0[0][31:0]), 64'(tbl[t].w0));
        chk({tbl[t].name, " a0 base FE"}, 64'(wq1[0][39:32]), 64'(8'hFE));
      end
      if (wq0.size() > 1) begin
        chk({tbl[t].name, " a1"}, 64'(wq0[1][39:32]), 64'(8'h01));
        chk({tbl[t].name, " w1"}, 64'(wq0[1][31:0]), 64'(tbl[t].w1));
        chk({tbl[t].name, " a1 base FE"}, 64'(wq1[1][39:32]), 64'(8'hFF));
      end
      chk({tbl[t].name, " done"}, 64'(done0), 64'(tbl[t].done));
      chk({tbl[t].name, " err"}, 64'(err0), 64'(tbl[t].err));
      chk({tbl[t].name, " core_rst"}, 64'(crst0), 64'(!tbl[t].done));
      chk({tbl[t].name, " ready"}, 64'(rdy0), 64'(!tbl[t].err));
    end

`ifdef IMEM_LOADER_CKSUM_EN
    // ERR holds against traffic until clear_i, then back to IDLE.
    vld = 1'b1; din = 8'hA5;
    repeat (3) @(posedge clk);
    #1 vld = 1'b0;
    chk("err hold", 64'(err0), 64'(1));
    chk("err ready", 64'(rdy0), 64'(0));
    chk("err no done", 64'(done0), 64'(0));
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    chk("clear err", 64'(err0), 64'(0));
    chk("clear ready", 64'(rdy0), 64'(1));
    chk("clear core_rst", 64'(crst0), 64'(1));
    wq0.delete(); wq1.delete(); wc0.delete();
    s = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    s.push_back(xsum(s, 2));
    model(s); send(s, 1'b0); compare("after clear");
`else
    do_reset();
    s = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    model(s); send(s, 1'b0); compare("load1");
`endif

    // clear_i ignored in DONE; non-sync ignored; SYNC restarts.
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    chk("clear in done", 64'(done0), 64'(1));
    wq0.delete(); wq1.delete(); wc0.delete();
    s = '{8'h33};
    send(s, 1'b0);
    chk("done ignore", 64'(done0), 64'(1));
    chk("done core_rst", 64'(crst0), 64'(0));
    s = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(xsum(s, 2));
`endif
    model(s);
    begin
      logic [7:0] h[$];
      h = '{8'hA5};
      send(h, 1'b0);
      chk("restart core_rst", 64'(crst0), 64'(1));
      chk("restart done", 64'(done0), 64'(0));
      void'(s.pop_front());
      send(s, 1'b0);
    end
    compare("restart");

    // Address wrap on the FE-based instance.
    do_reset();
    s = '{8'hA5, 8'h03};
    for (int k = 0; k < 12; k++) s.push_back(8'(k * 17 + 3));
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(xsum(s, 2));
`endif
    model(s); send(s, 1'b1); compare("wrap");
    if (wq1.size() == 3) chk("wrap addr00", 64'(wq1[2][39:32]), 64'(8'h00));
    else chk("wrap count", 64'(wq1.size()), 64'(3));

    // Reset arriving with a write strobe pending.
    do_reset();
    s = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33};
    send(s, 1'b0);
    vld = 1'b1; din = 8'h44; @(posedge clk);
    #1 rst = 1'b0; vld = 1'b0;
    @(negedge clk);
    chk("midrst we", 64'(we0), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst nwr", 64'(wq0.size()), 64'(0));
    chk("midrst addr", 64'(a0), 64'(0));
    chk("midrst wdata", 64'(d0), 64'(0));
    chk("midrst core_rst", 64'(crst0), 64'(1));
    chk("midrst done", 64'(done0), 64'(0));
    chk("midrst err", 64'(err0), 64'(0));
    chk("midrst ready", 64'(rdy0), 64'(1));

    // N=0: 256 words streamed back to back.
    do_reset();
    s = '{8'hA5, 8'h00};
    for (int k = 0; k < 1024; k++) s.push_back(8'($urandom));
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(xsum(s, 2));
`endif
    model(s); send(s, 1'b0); compare("n256");
    bad = 0;
    for (int k = 1; k < wc0.size(); k++) if (wc0[k] - wc0[k-1] != 4) bad++;
    chk("n256 spacing", 64'(bad), 64'(0));

    // Randomized loads: junk prefix, gaps, truncation, corrupt checksum.
    for (int t = 0; t < 25; t++) begin
      do_reset();
      s.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        s.push_back(b);
      end
      n = $urandom_range(1, 6);
      s.push_back(8'hA5);
      s.push_back(8'(n));
      for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom));
`ifdef IMEM_LOADER_CKSUM_EN
      b = xsum(s, s.size() - 4 * n);
      s.push_back(($urandom_range(0, 3) == 0) ? (b ^ 8'h01) : b);
`endif
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) void'(s.pop_back());
      model(s); send(s, 1'b1); compare("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
